// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit.
// Issues sequential word-aligned fetches under a credit limit (FIFO entries
// plus in-flight requests never exceed FIFO_DEPTH). In-order responses are tagged
// with their fetch pc from a small pc queue and buffered for decode. A redirect
// flushes the buffer, restarts fetch and discards responses still owed to the old stream.
// Optional feature macro: IFU_PERF_CNT_EN adds perf_fetched/perf_dropped/perf_stall.
module ysyx_23060187_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_stall
`endif
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  // IDLE: no credits; FETCH: requesting; DRAIN: old-stream responses still owed
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} ifu_state_e;

  ifu_state_e    state;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_nxt;
  logic [CW-1:0] drop_cnt;

  // in-order pc of every in-flight request (old and new stream alike)
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;

  // instruction buffer
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic [CW:0]   used;
  logic          credit;
  logic          accept;
  logic          resp;
  logic          drop;
  logic          push;
  logic          pop;

  assign used     = {1'b0, cnt} + {1'b0, outst};
  assign credit   = used < DEPTH_W;
  assign accept   = imem_req_valid && imem_req_ready;
  // a response with nothing in flight cannot be legal; ignore it rather than underflow
  assign resp     = imem_resp_valid && (outst != '0);
  // anything arriving in a redirect cycle belongs to the stream being abandoned
  assign drop     = resp && (redirect_valid || (drop_cnt != '0));
  assign push     = resp && !drop;
  assign pop      = inst_valid && inst_ready;

  assign outst_nxt = outst + CW'(accept) - CW'(resp);

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (cnt != '0);
  assign inst          = fifo_inst[rd_ptr];
  assign inst_pc       = fifo_pc[rd_ptr];

  // fetch status decode and request gating (no request while in reset or redirecting)
  always_comb begin
    state = FETCH;
    if (!credit)
      state = IDLE;
    else if (drop_cnt != '0)
      state = DRAIN;
    imem_req_valid = rst && (state != IDLE) && !redirect_valid;
  end

  // fetch pointer, in-flight count and stale-response drop count
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
        drop_cnt <= outst_nxt;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // pc queue: push on accept, pop on every response (kept or dropped)
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        pcq[i] <= '0;
    end else begin
      if (accept) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + AW'(1);
      end
      if (resp)
        pcq_rd <= pcq_rd + AW'(1);
    end
  end

  // instruction buffer: registered head, flushed by redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo_inst[wr_ptr] <= imem_resp_data;
        fifo_pc[wr_ptr]   <= pcq[pcq_rd];
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

`ifdef IFU_PERF_CNT_EN
  // free-running event counters, wrap mod 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      if (drop)
        perf_dropped <= perf_dropped + 32'd1;
      if (inst_ready && !inst_valid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Directed bench for ysyx_23060187_ifu. A small memory model answers accepted
// requests in order; expected {pc, inst} pairs are queued as stimulus is driven
// and compared whenever decode takes an instruction.
module tb_ysyx_23060187_ifu;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [31:0] perf_stall;
`endif

  ysyx_23060187_ifu #(.RESET_PC(RPC), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped),
    .perf_stall      (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  int          a0;
  logic        mem_stall = 1'b0;
  logic [31:0] sb_pc;
  logic [31:0] hold_addr;
  logic [31:0] exp_q  [$];
  logic [31:0] pend_q [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(sb_pc);
      sb_pc = sb_pc + 32'd4;
    end
  endtask

  // wait until every queued instruction has been taken, then stop consuming
  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
  endtask

  // memory: note accepts just before the edge that takes them
  initial forever begin
    @(negedge clk);
    if (rst && imem_req_valid && imem_req_ready) begin
      pend_q.push_back(imem_req_addr);
      acc_cnt++;
    end
  end

  // memory: answer in order, earliest the cycle after accept
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        pend_q.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end else if (!mem_stall && pend_q.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_of(pend_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // scoreboard: every decode handshake must match the head of the expected queue
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!rst)
      pop_cnt = 0;
    else if (inst_valid && inst_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0)
        check("extra_inst", 32'd0, 32'd1);
      else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_word", inst, word_of(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // A: always-ready memory, streaming decode, latency and throughput
    @(posedge clk); #1;
    rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    sb_pc = RPC; push_exp(8);
    @(negedge clk);
    check("a_first_req_valid", 32'(imem_req_valid), 32'd1);
    check("a_first_req_addr", imem_req_addr, RPC);
    check("a_n0_inst_valid", 32'(inst_valid), 32'd0);
    tick(); @(negedge clk);
    check("a_n1_inst_valid", 32'(inst_valid), 32'd0);
    check("a_n1_req_addr", imem_req_addr, RPC + 32'd4);
    tick(); @(negedge clk);
    check("a_n2_inst_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(); @(negedge clk);
      check("a_stream_valid", 32'(inst_valid), 32'd1);
    end
    wait_drain("a_drain", 20);

    // reset in the middle of traffic
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);

    // B: decode stalled -> exactly FIFO_DEPTH requests, then one pop per cycle
    @(posedge clk); #1;
    rst = 1'b1; inst_ready = 1'b0; a0 = acc_cnt;
    repeat (12) tick();
    @(negedge clk);
    check("b_accepts", 32'(acc_cnt - a0), 32'd4);
    check("b_req_idle", 32'(imem_req_valid), 32'd0);
    check("b_full_valid", 32'(inst_valid), 32'd1);
    @(posedge clk); #1;
    inst_ready = 1'b1; sb_pc = RPC; push_exp(12);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b_one_per_cycle", 32'(inst_valid), 32'd1);
    end
    #1;
    wait_drain("b_drain", 5);
    repeat (6) tick();

    // C: redirect with 2 outstanding, coincident with a decode handshake
    mem_stall = 1'b1; inst_ready = 1'b1; a0 = acc_cnt;
    push_exp(2);
    wait_drain("c_pre_drain", 10);
    repeat (4) tick();
    @(negedge clk);
    check("c_outstanding_accepts", 32'(acc_cnt - a0), 32'd2);
    check("c_credit_idle", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002; inst_ready = 1'b1;
    push_exp(1);
    @(negedge clk);
    check("c_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0; mem_stall = 1'b0;
    sb_pc = 32'h8000_1000; push_exp(8);
    @(negedge clk);
    check("c_flush_inst_valid", 32'(inst_valid), 32'd0);
    check("c_new_req_valid", 32'(imem_req_valid), 32'd1);
    check("c_new_req_addr", imem_req_addr, 32'h8000_1000);
    wait_drain("c_drain", 40);
    repeat (8) tick();
`ifdef IFU_PERF_CNT_EN
    check("c_perf_dropped", perf_dropped, 32'd2);
    check("c_perf_fetched", perf_fetched, 32'(pop_cnt + 4 + 1));
`endif

    // D: redirect coincident with a response and a handshake; one left outstanding
    mem_stall = 1'b1; inst_ready = 1'b1; a0 = acc_cnt;
    push_exp(2);
    wait_drain("d_pre_drain", 10);
    repeat (4) tick();
    @(negedge clk);
    check("d_outstanding_accepts", 32'(acc_cnt - a0), 32'd2);
    @(posedge clk); #1;
    mem_stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_2003; inst_ready = 1'b1;
    push_exp(1);
    @(negedge clk);
    check("d_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    sb_pc = 32'h8000_2000; push_exp(8);
    @(negedge clk);
    check("d_flush_inst_valid", 32'(inst_valid), 32'd0);
    wait_drain("d_drain", 40);
    repeat (8) tick();
`ifdef IFU_PERF_CNT_EN
    check("d_perf_dropped", perf_dropped, 32'd4);
    check("d_perf_fetched", perf_fetched, 32'(pop_cnt + 4 + 2));
`endif

    // E: memory not ready for 5 cycles -> request held, accepted once
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    push_exp(4);
    wait_drain("e_pre_drain", 10);
    hold_addr = sb_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("e_hold_valid", 32'(imem_req_valid), 32'd1);
      check("e_hold_addr", imem_req_addr, hold_addr);
      @(posedge clk); #1;
    end
    a0 = acc_cnt;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("e_accepted_once", 32'(acc_cnt - a0), 32'd1);
    check("e_next_addr", imem_req_addr, hold_addr + 32'd4);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    push_exp(1);
    wait_drain("e_drain", 10);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
